spi_txn_sequencer: RTL

- Byte-stream front end for the SPI master engine, sitting directly upstream and downstream of it.
- Buffers host TX bytes in a FIFO and launches one master transfer per byte with a single-cycle start pulse.
- Waits for the master's done pulse, captures the received byte into an RX FIFO, and enforces an inter-byte gap.
- Provides a done-timeout watchdog; host side uses valid/ready handshakes on both streams.

---
 rtl/spi_txn_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_txn_sequencer.sv
// Byte-stream front end for the SPI master engine: TX/RX byte FIFOs, one master
// launch per byte, an inter-byte gap after each done, and a done-timeout watchdog.
module spi_txn_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   spi_start,
    output logic [7:0]             spi_tx_byte,
    input  logic [7:0]             spi_rx_byte,
    input  logic                   spi_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   err_timeout,
    input  logic                   err_clear
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_next;
    logic [GW-1:0] gap_cnt, gap_cnt_next;
    logic          launch;
    logic          rx_push;
    logic          tmo_fire;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic          tx_push;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic          rx_pop;

    assign tx_ready = (tx_level != LW'(DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = (rx_level != '0);
    assign rx_pop   = rx_ready && rx_valid;
    assign rx_data  = rx_mem[rx_rd_ptr];
    assign busy     = (state != IDLE) || (tx_level != '0);

    // TX FIFO: host writes, launch pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (launch)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({tx_push, launch})
                2'b10:   tx_level <= tx_level + LW'(1);
                2'b01:   tx_level <= tx_level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    end

    // RX FIFO: done pushes, host pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LW'(1);
                2'b01:   rx_level <= rx_level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= spi_rx_byte;
    end

    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        gap_cnt_next = gap_cnt;
        launch       = 1'b0;
        rx_push      = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            IDLE: begin
                // Holding off while RX is full is what makes RX overflow impossible
                if ((tx_level != '0) && (rx_level < LW'(DEPTH))) begin
                    launch       = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    rx_push      = 1'b1;
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    tmo_fire   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            spi_start   <= 1'b0;
            spi_tx_byte <= '0;
            err_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            gap_cnt   <= gap_cnt_next;
            spi_start <= launch;
            if (launch) spi_tx_byte <= tx_mem[tx_rd_ptr];
            // A timeout in the same cycle as err_clear leaves the flag set
            if (tmo_fire) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
